// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ message sources.
// A grant lasts for a whole message; a lock timeout reclaims the UART from a stalled owner.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      lock_timeout
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int TMR_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [ID_W-1:0]   ID_ZERO    = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]   ID_LAST    = ID_W'(N_REQ - 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0]  TMR_MAX    = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
  localparam logic [N_REQ-1:0]  REQ_ZERO   = {N_REQ{1'b0}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [ID_W-1:0]     grant_r, grant_s;
  logic [ID_W-1:0]     last_grant_r, last_grant_s;
  logic [TMR_W-1:0]    timer_r, timer_s;
  logic [ID_W-1:0]     winner_s, idx_s;
  logic                found_s;
  logic [DATA_W-1:0]   req_bytes_s [N_REQ];
  logic                tx_valid_s, busy_s, lock_timeout_s;
  logic [DATA_W-1:0]   tx_data_s;
  logic [N_REQ-1:0]    req_ready_s;

  // Split the flat data bus into one byte per requester
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes_s[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    found_s  = 1'b0;
    winner_s = ID_ZERO;
    idx_s    = ID_ZERO;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = ID_W'((int'(last_grant_r) + k) % N_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Next-state logic and the SEND datapath, all steered by the registered grant
  always_comb begin
    state_s        = state_r;
    grant_s        = grant_r;
    last_grant_s   = last_grant_r;
    timer_s        = timer_r;
    tx_valid_s     = 1'b0;
    tx_data_s      = DATA_ZERO;
    req_ready_s    = REQ_ZERO;
    busy_s         = 1'b0;
    lock_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_SEND;
          grant_s = winner_s;
          timer_s = TMR_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        busy_s               = 1'b1;
        tx_valid_s           = req_valid[grant_r];
        tx_data_s            = req_bytes_s[grant_r];
        req_ready_s[grant_r] = tx_ready & req_valid[grant_r];
        if (tx_valid_s && tx_ready) begin
          if (req_last[grant_r]) begin
            last_grant_s = grant_r;
            state_s      = ST_IDLE;
          end else begin
            timer_s = TMR_ZERO;
          end
        end else if (!req_valid[grant_r]) begin
          // Only an owner that stops offering bytes ages the lock; UART stalls do not
          if (timer_r == TMR_LAST) begin
            lock_timeout_s = 1'b1;
            last_grant_s   = grant_r;
            state_s        = ST_IDLE;
          end else if (timer_r != TMR_MAX) begin
            timer_s = timer_r + TMR_ONE;
          end else begin
            timer_s = timer_r;
          end
        end else begin
          timer_s = timer_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, grant and timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= ID_ZERO;
      last_grant_r <= ID_LAST;
      timer_r      <= TMR_ZERO;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      timer_r      <= timer_s;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the reset edge lands
  assign tx_valid     = reset ? 1'b0      : tx_valid_s;
  assign tx_data      = reset ? DATA_ZERO : tx_data_s;
  assign req_ready    = reset ? REQ_ZERO  : req_ready_s;
  assign busy         = reset ? 1'b0      : busy_s;
  assign lock_timeout = reset ? 1'b0      : lock_timeout_s;
  assign grant_id     = reset ? ID_ZERO   : grant_r;

endmodule
